// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, reset pointer and output-register state encoding for the operand arbiter
package alu_arb_pkg;
  localparam int SRC_W = 2;
  localparam int N_REQ = 4;
  localparam logic [SRC_W-1:0] RST_PTR = 2'd3;
  typedef enum logic {ST_EMPTY, ST_FULL} state_e;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotate-priority encoder, scans ptr+1 .. ptr+4 (mod 4) for the first valid requester
module rr_pick4
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] valid_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SRC_W-1:0] winner_o
);
  logic [N_REQ-1:0] rot;
  logic [SRC_W-1:0] off;
  // rot[j] is requester (ptr+1+j) mod 4
  assign rot = N_REQ'({valid_i, valid_i} >> ({1'b0, ptr_i} + 3'd1));
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign winner_o = ptr_i + 2'd1 + off;
  assign found_o = |valid_i;
endmodule

// File: rtl/alu_operand_arbiter.sv
// alu_operand_arbiter: round-robin grant of the shared ALU operand mux into one valid/ready output register.
// Optional ARB_LOCK_EN adds req_lock so a requester can hold the grant; req_data0..3 feed the external mux directly.
module alu_operand_arbiter
  import alu_arb_pkg::*;
#(
  parameter int               DATA_W  = 32,
  parameter logic [SRC_W-1:0] RST_PTR = alu_arb_pkg::RST_PTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  output logic [SRC_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_y,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]  req_lock,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SRC_W-1:0]  out_src,
  input  logic              out_ready
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d, ptr_q, ptr_d, win;
  logic [N_REQ-1:0]  elig;
  logic              found, load;
`ifdef ARB_LOCK_EN
  logic              lock_q, lock_d;
  logic [SRC_W-1:0]  owner_q, owner_d;
  assign elig = lock_q ? req_valid & (N_REQ'(1) << owner_q) : req_valid;
  // A load from the owner re-evaluates its lock; an idle owner releases it
  always_comb begin
    lock_d = load ? req_lock[win] : lock_q && req_valid[owner_q];
    owner_d = load ? win : owner_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock_q <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q <= lock_d;
      owner_q <= owner_d;
    end
`else
  assign elig = req_valid;
`endif
  rr_pick4 u_pick (
    .valid_i (elig),
    .ptr_i   (ptr_q),
    .found_o (found),
    .winner_o(win)
  );
  assign out_valid = state_q == ST_FULL;
  assign out_data = data_q;
  assign out_src = src_q;
  assign load = !rst && found && (!out_valid || out_ready);
  assign req_ready = load ? N_REQ'(1) << win : '0;
  assign mux_sel = (!rst && found) ? win : '0;
  always_comb begin
    state_d = load ? ST_FULL : out_ready ? ST_EMPTY : state_q;
    data_d = load ? mux_y : data_q;
    src_d = load ? win : src_q;
    ptr_d = load ? win : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q <= '0;
      src_q <= '0;
      ptr_q <= RST_PTR;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
    end
endmodule
